// File: rtl/lfsr_prbs_gen.sv
// -----------------------------------------------------------------------------
// lfsr_prbs_gen
//
// Parametrised Fibonacci LFSR pseudo-random bit generator. Successor to the
// fixed 5-bit free-running LFSR, used by PRBS/noise consumers in the lab
// datapath.
//
// The LFSR shifts right; the new MSB is the parity of the tapped bits, and the
// bit leaving at q[0] is packed LSB-first into WORD_W-bit output words. Words
// are offered on a valid/ready stream. Stepping stalls only when the word
// currently being assembled would complete while the previous word is still
// waiting for the consumer, so no bit is ever lost.
//
// Parameters
//   WIDTH   LFSR state width (3..32)
//   TAPS    feedback mask, fb = ^(q & TAPS)
//   SEED    reset state, also substituted for an all-zero runtime load
//   WORD_W  bits packed per output word (1..32)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   en          request one LFSR step this cycle
//   load        load seed_in (wins over en; no step that cycle)
//   seed_in     runtime seed
//   seed_bad    one-cycle pulse after a load with seed_in == 0
//   q           current LFSR state
//   out_valid   out_word holds an unconsumed word
//   out_ready   consumer accepts out_word when out_valid && out_ready
//   out_word    packed bits, LSB = earliest shifted-out bit
//
// Optional feature (macro LFSR_PERIOD_CHECK_EN)
//   period_done one-cycle pulse when a step returns q to the last reset/load
//               state
//   period      number of steps that round trip took (0 after reset)
// -----------------------------------------------------------------------------
module lfsr_prbs_gen #(
  parameter int              WIDTH  = 5,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(5'b00101),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(5'b00001),
  parameter int              WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  seed_in,
  output logic              seed_bad,
  output logic [WIDTH-1:0]  q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word
`ifdef LFSR_PERIOD_CHECK_EN
  ,
  output logic              period_done,
  output logic [WIDTH-1:0]  period
`endif
);

  // A one-bit word still needs a one-bit counter to keep the logic uniform.
  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic [WIDTH-1:0]  q_reg;
  logic [WIDTH-1:0]  q_step;
  logic [WIDTH-1:0]  load_val;
  logic              fb;
  logic [WORD_W-1:0] acc_reg;
  logic [WORD_W-1:0] word_next;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              out_valid_reg;
  logic [WORD_W-1:0] out_word_reg;
  logic              seed_bad_reg;
  logic              last_bit;
  logic              stall;
  logic              step;
  logic              word_done;

  // ---------------------------------------------------------------------------
  // Step control
  // ---------------------------------------------------------------------------
  always_comb begin
    fb        = ^(q_reg & TAPS);
    q_step    = {fb, q_reg[WIDTH-1:1]};
    // An all-zero seed would lock the LFSR, so it is replaced by SEED.
    load_val  = (seed_in == '0) ? SEED : seed_in;
    last_bit  = (bit_cnt_reg == LAST_BIT);
    // Only the step that would overwrite a still-pending word has to wait.
    stall     = last_bit && out_valid_reg && !out_ready;
    step      = en && !load && !stall;
    word_done = step && last_bit;
  end

  // Accumulator with the current output bit merged in at bit_cnt; on the last
  // bit this is the completed word.
  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_word
      assign word_next[gi] = (bit_cnt_reg == CNT_W'(gi)) ? q_reg[0] : acc_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // LFSR state and word assembly
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg       <= SEED;
      acc_reg     <= '0;
      bit_cnt_reg <= '0;
    end else if (load) begin
      q_reg       <= load_val;
      acc_reg     <= '0;
      bit_cnt_reg <= '0;
    end else if (step) begin
      q_reg       <= q_step;
      acc_reg     <= word_next;
      bit_cnt_reg <= word_done ? '0 : bit_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stream. A word completing in the same cycle as a handshake replaces
  // the consumed one directly, so out_valid stays high without a bubble.
  // Loads do not touch a pending word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      out_word_reg  <= '0;
    end else if (word_done) begin
      out_valid_reg <= 1'b1;
      out_word_reg  <= word_next;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed_bad_reg <= 1'b0;
    end else begin
      seed_bad_reg <= load && (seed_in == '0);
    end
  end

  assign q         = q_reg;
  assign out_valid = out_valid_reg;
  assign out_word  = out_word_reg;
  assign seed_bad  = seed_bad_reg;

`ifdef LFSR_PERIOD_CHECK_EN
  // ---------------------------------------------------------------------------
  // Period measurement: counts steps since the last reset/load and reports the
  // count when the sequence comes back to that starting state.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] ref_reg;
  logic [WIDTH-1:0] step_cnt_reg;
  logic [WIDTH-1:0] period_reg;
  logic             period_done_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_reg         <= SEED;
      step_cnt_reg    <= '0;
      period_reg      <= '0;
      period_done_reg <= 1'b0;
    end else begin
      period_done_reg <= 1'b0;
      if (load) begin
        ref_reg      <= load_val;
        step_cnt_reg <= '0;
      end else if (step) begin
        if (q_step == ref_reg) begin
          period_reg      <= step_cnt_reg + 1'b1;
          period_done_reg <= 1'b1;
          step_cnt_reg    <= '0;
        end else begin
          step_cnt_reg    <= step_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign period      = period_reg;
  assign period_done = period_done_reg;
`endif

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_prbs_gen
//
// Self-checking bench for lfsr_prbs_gen with default parameters (5-bit LFSR,
// taps 00101, seed 00001, 8-bit words). A directed vector table covers the
// documented start-up sequence, first word, seed loads and load+en; hand
// sequences cover backpressure and mid-word reset; a randomized run is
// compared against a bit-queue reference model every cycle.
// -----------------------------------------------------------------------------
module tb_lfsr_prbs_gen;

  localparam int W      = 5;
  localparam int WORD_W = 8;
  localparam int TAPS_I = 5;   // 5'b00101
  localparam int SEED_I = 1;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [4:0] seed_in;
  logic       seed_bad;
  logic [4:0] q;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_word;
`ifdef LFSR_PERIOD_CHECK_EN
  logic       period_done;
  logic [4:0] period;
`endif

  lfsr_prbs_gen dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .seed_in    (seed_in),
    .seed_bad   (seed_bad),
    .q          (q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word)
`ifdef LFSR_PERIOD_CHECK_EN
    ,
    .period_done(period_done),
    .period     (period)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: LFSR arithmetic plus a queue of bits not yet packed.
  // ---------------------------------------------------------------------------
  int m_q;
  bit m_valid;
  int m_word;
  bit m_bad;
  int m_bits[$];
  int m_ref;
  int m_cnt;
  int m_period;
  bit m_done;

  function automatic int lfsr_next(input int s);
    int fb;
    fb = $countones(s & TAPS_I) % 2;
    return (fb << (W - 1)) | (s >> 1);
  endfunction

  // k-th word (0-based) of the free-running stream starting at SEED.
  function automatic int free_word(input int k);
    int s;
    int w;
    s = SEED_I;
    w = 0;
    for (int i = 0; i < (k + 1) * WORD_W; i++) begin
      if (i >= k * WORD_W) w = w | ((s & 1) << (i - k * WORD_W));
      s = lfsr_next(s);
    end
    return w;
  endfunction

  task automatic model_reset();
    m_q      = SEED_I;
    m_valid  = 1'b0;
    m_word   = 0;
    m_bad    = 1'b0;
    m_bits.delete();
    m_ref    = SEED_I;
    m_cnt    = 0;
    m_period = 0;
    m_done   = 1'b0;
  endtask

  task automatic model_clock(input bit e, input bit l, input int s, input bit r);
    bit consumed;
    bit stall;
    int w;
    consumed = m_valid && r;
    m_bad    = l && (s == 0);
    m_done   = 1'b0;
    if (l) begin
      m_q = (s == 0) ? SEED_I : s;
      m_bits.delete();
      m_ref = m_q;
      m_cnt = 0;
      if (consumed) m_valid = 1'b0;
    end else begin
      stall = e && (m_bits.size() == WORD_W - 1) && m_valid && !r;
      if (e && !stall) begin
        m_bits.push_back(m_q & 1);
        m_q = lfsr_next(m_q);
        m_cnt++;
        if (m_q == m_ref) begin
          m_period = m_cnt;
          m_done   = 1'b1;
          m_cnt    = 0;
        end
        if (m_bits.size() == WORD_W) begin
          w = 0;
          for (int i = 0; i < WORD_W; i++) w = w | (m_bits[i] << i);
          m_word  = w;
          m_valid = 1'b1;
          m_bits.delete();
        end else if (consumed) begin
          m_valid = 1'b0;
        end
      end else if (consumed) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " q"}, int'(q), m_q);
    chk({tag, " out_valid"}, int'(out_valid), int'(m_valid));
    chk({tag, " out_word"}, int'(out_word), m_word);
    chk({tag, " seed_bad"}, int'(seed_bad), int'(m_bad));
`ifdef LFSR_PERIOD_CHECK_EN
    chk({tag, " period_done"}, int'(period_done), int'(m_done));
    chk({tag, " period"}, int'(period), m_period);
`endif
  endtask

  // Apply one cycle of inputs, advance the model, compare after the edge.
  task automatic cycle(input bit e, input bit l, input int s, input bit r, input string tag);
    en        = e;
    load      = l;
    seed_in   = 5'(s);
    out_ready = r;
    @(posedge clk);
    model_clock(e, l, s, r);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    en        = 1'b0;
    load      = 1'b0;
    seed_in   = '0;
    out_ready = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         en;
    bit         load;
    logic [4:0] seed;
    bit         ready;
    logic [4:0] exp_q;
    bit         exp_valid;
    logic [7:0] exp_word;
    bit         exp_bad;
  } vec_t;

  vec_t vecs[24];

  initial begin
    int st;
    int stream_word;

    vecs[0]  = '{1, 0, 5'h00, 1, 5'b10000, 0, 8'h00, 0};
    vecs[1]  = '{1, 0, 5'h00, 1, 5'b01000, 0, 8'h00, 0};
    vecs[2]  = '{1, 0, 5'h00, 1, 5'b00100, 0, 8'h00, 0};
    vecs[3]  = '{1, 0, 5'h00, 1, 5'b10010, 0, 8'h00, 0};
    vecs[4]  = '{1, 0, 5'h00, 1, 5'b01001, 0, 8'h00, 0};
    vecs[5]  = '{1, 0, 5'h00, 1, 5'b10100, 0, 8'h00, 0};
    vecs[6]  = '{1, 0, 5'h00, 1, 5'b11010, 0, 8'h00, 0};
    vecs[7]  = '{1, 0, 5'h00, 1, 5'b01101, 1, 8'h21, 0};
    vecs[8]  = '{1, 0, 5'h00, 1, 5'b00110, 0, 8'h21, 0};
    vecs[9]  = '{0, 1, 5'h00, 1, 5'b00001, 0, 8'h21, 1};
    vecs[10] = '{0, 0, 5'h00, 1, 5'b00001, 0, 8'h21, 0};
    vecs[11] = '{0, 1, 5'h1F, 1, 5'b11111, 0, 8'h21, 0};
    vecs[12] = '{1, 0, 5'h00, 1, 5'b01111, 0, 8'h21, 0};
    vecs[13] = '{1, 0, 5'h00, 1, 5'b00111, 0, 8'h21, 0};
    vecs[14] = '{1, 0, 5'h00, 1, 5'b00011, 0, 8'h21, 0};
    vecs[15] = '{1, 1, 5'h0A, 1, 5'b01010, 0, 8'h21, 0};
    vecs[16] = '{1, 0, 5'h00, 1, 5'b00101, 0, 8'h21, 0};
    vecs[17] = '{1, 0, 5'h00, 1, 5'b00010, 0, 8'h21, 0};
    vecs[18] = '{1, 0, 5'h00, 1, 5'b00001, 0, 8'h21, 0};
    vecs[19] = '{1, 0, 5'h00, 1, 5'b10000, 0, 8'h21, 0};
    vecs[20] = '{1, 0, 5'h00, 1, 5'b01000, 0, 8'h21, 0};
    vecs[21] = '{1, 0, 5'h00, 1, 5'b00100, 0, 8'h21, 0};
    vecs[22] = '{1, 0, 5'h00, 1, 5'b10010, 0, 8'h21, 0};
    vecs[23] = '{1, 0, 5'h00, 1, 5'b01001, 1, 8'h0A, 0};

    reset     = 1'b1;
    en        = 1'b0;
    load      = 1'b0;
    seed_in   = '0;
    out_ready = 1'b0;
    #2;
    do_reset();
    chk("reset q=SEED", int'(q), 1);
    chk("reset out_word", int'(out_word), 0);

    // ---- table ----
    for (int i = 0; i < 24; i++) begin
      en        = vecs[i].en;
      load      = vecs[i].load;
      seed_in   = vecs[i].seed;
      out_ready = vecs[i].ready;
      @(posedge clk);
      model_clock(vecs[i].en, vecs[i].load, int'(vecs[i].seed), vecs[i].ready);
      #1;
      chk($sformatf("vec%0d q", i), int'(q), int'(vecs[i].exp_q));
      chk($sformatf("vec%0d out_valid", i), int'(out_valid), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d out_word", i), int'(out_word), int'(vecs[i].exp_word));
      chk($sformatf("vec%0d seed_bad", i), int'(seed_bad), int'(vecs[i].exp_bad));
      $display("vec %0d en=%0b load=%0b seed=%02h ready=%0b -> q=%05b valid=%0b word=%02h bad=%0b",
               i, vecs[i].en, vecs[i].load, vecs[i].seed, vecs[i].ready, q, out_valid, out_word, seed_bad);
    end

    // ---- backpressure: ready low for 20 cycles after first word ----
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1, "bp fill");
    chk("bp first word", int'(out_word), 8'h21);
    chk("bp first valid", int'(out_valid), 1);
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, "bp stall");
    st = SEED_I;
    for (int i = 0; i < 15; i++) st = lfsr_next(st);
    chk("bp q held after 7 steps", int'(q), st);
    chk("bp word held", int'(out_word), 8'h21);
    chk("bp valid held", int'(out_valid), 1);
    cycle(1, 0, 0, 1, "bp release");
    stream_word = free_word(1);
    chk("bp second word no bubble", int'(out_valid), 1);
    chk("bp second word vs free-run", int'(out_word), stream_word);
    $display("backpressure: second word %02h", out_word);
    cycle(1, 0, 0, 1, "bp drain");
    chk("bp drained", int'(out_valid), 0);

    // ---- asynchronous reset mid-word with a pending word ----
    for (int i = 0; i < 11; i++) cycle(1, 0, 0, 0, "mid fill");
    chk("mid pending valid", int'(out_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid reset q", int'(q), SEED_I);
    chk("mid reset valid", int'(out_valid), 0);
    chk("mid reset word", int'(out_word), 0);
    $display("mid-word reset: q=%05b valid=%0b word=%02h", q, out_valid, out_word);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1, "post reset");
    chk("post reset first word", int'(out_word), 8'h21);

`ifdef LFSR_PERIOD_CHECK_EN
    // ---- period measurement ----
    do_reset();
    for (int i = 1; i <= 62; i++) begin
      cycle(1, 0, 0, 1, "period run");
      if (i == 31 || i == 62) begin
        chk("period_done at 31k", int'(period_done), 1);
        chk("period value", int'(period), 31);
        $display("period pulse at step %0d period=%0d", i, period);
      end
    end
`endif

    // ---- randomized run against the model ----
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit e;
      bit l;
      bit r;
      int s;
      e = ($urandom_range(0, 9) < 8);
      l = ($urandom_range(0, 29) == 0);
      r = $urandom_range(0, 1) == 1;
      s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31));
      cycle(e, l, s, r, "rand");
      if (l || (out_valid && r)) begin
        $display("rand %0d en=%0b load=%0b seed=%02h ready=%0b q=%05b valid=%0b word=%02h",
                 i, e, l, s, r, q, out_valid, out_word);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
